// File: rtl/mul_wb_collector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_wb_collector_pkg                                         |
// | Description : Shared widths and the writeback entry type used by the       |
// |               multiplier/divider writeback collector and its FIFO.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mul_wb_collector_pkg;

  localparam int XLEN          = 64;
  localparam int TRANS_ID_BITS = 3;

  typedef logic [XLEN-1:0] xlen_t;

  // One buffered writeback: result data plus the scoreboard transaction ID.
  typedef struct packed {
    xlen_t                    result;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/mul_wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_wb_fifo                                                  |
// | Description : Generic DEPTH-entry FIFO of wb_entry_t with async reset and  |
// |               synchronous flush. Head data comes straight from storage     |
// |               registers.                                                   |
// | Ports       : clk_i, rst_i, flush_i  - clock, async reset, sync flush      |
// |               push_i / data_i        - write request and entry            |
// |               pop_i / data_o         - read request and head entry        |
// |               full_o, empty_o, count_o - occupancy status                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mul_wb_fifo
  import mul_wb_collector_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  wb_entry_t        data_i,
  input  logic             pop_i,
  output wb_entry_t        data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_pop_en;
  logic w_push_en;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign count_o = r_count;
  assign data_o  = r_mem[r_rptr];

  // A push into a full FIFO is only honoured when a pop frees the head slot.
  assign w_pop_en  = pop_i & ~empty_o;
  assign w_push_en = push_i & (~full_o | w_pop_en);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_en) r_wptr <= ptr_next(r_wptr);
      if (w_pop_en)  r_rptr <= ptr_next(r_rptr);
      if (w_push_en && !w_pop_en)      r_count <= r_count + CNT_W'(1);
      else if (w_pop_en && !w_push_en) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage needs no reset: occupancy is tracked solely by r_count.
  always_ff @(posedge clk_i) begin
    if (w_push_en && !flush_i) r_mem[r_wptr] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/mul_wb_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_wb_collector                                             |
// | Description : Merges non-stallable multiplier result pulses and held       |
// |               divider results onto one backpressured writeback port, and   |
// |               issues the multiplier credit that guarantees a buffer slot.  |
// | Ports       : clk_i, rst_i, flush_i                                        |
// |               mul_valid_i/result/trans_id, mul_ready_o  - multiplier side  |
// |               div_valid_i/result/trans_id, div_ready_o  - divider side     |
// |               wb_valid_o/result/trans_id, wb_ready_i    - writeback side   |
// |               TRANS_ID_BITS must match the package entry type width.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mul_wb_collector
  import mul_wb_collector_pkg::*;
#(
  parameter int DEPTH         = 2,
  parameter int TRANS_ID_BITS = mul_wb_collector_pkg::TRANS_ID_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     mul_valid_i,
  input  logic [XLEN-1:0]          mul_result_i,
  input  logic [TRANS_ID_BITS-1:0] mul_trans_id_i,
  output logic                     mul_ready_o,
  input  logic                     div_valid_i,
  input  logic [XLEN-1:0]          div_result_i,
  input  logic [TRANS_ID_BITS-1:0] div_trans_id_i,
  output logic                     div_ready_o,
  output logic                     wb_valid_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  input  logic                     wb_ready_i
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        w_mul_entry;
  wb_entry_t        w_head;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_out_en;
  logic             w_push;
  logic             w_pop;

  assign w_mul_entry.result   = mul_result_i;
  assign w_mul_entry.trans_id = mul_trans_id_i;

  // Reset and flush both blank the writeback port and the divider handshake.
  assign w_out_en = ~rst_i & ~flush_i;

  // A multiplier result bypasses only into an empty FIFO with a ready sink;
  // in every other non-flush case it must be buffered.
  assign w_push = mul_valid_i & ~flush_i & ~(w_empty & wb_ready_i);
  assign w_pop  = ~w_empty & wb_ready_i & ~flush_i;

  mul_wb_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (w_push),
    .data_i  (w_mul_entry),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // Priority: FIFO head, then multiplier bypass, then divider.
  always_comb begin
    wb_valid_o    = 1'b0;
    wb_result_o   = '0;
    wb_trans_id_o = '0;
    if (w_out_en) begin
      if (!w_empty) begin
        wb_valid_o    = 1'b1;
        wb_result_o   = w_head.result;
        wb_trans_id_o = w_head.trans_id;
      end else if (mul_valid_i) begin
        wb_valid_o    = 1'b1;
        wb_result_o   = mul_result_i;
        wb_trans_id_o = mul_trans_id_i;
      end else if (div_valid_i) begin
        wb_valid_o    = 1'b1;
        wb_result_o   = div_result_i;
        wb_trans_id_o = div_trans_id_i;
      end
    end
  end

  assign div_ready_o = div_valid_i & wb_ready_i & w_empty & ~mul_valid_i & w_out_en;

  // Credit ignores a same-cycle pop, so an op issued now always finds a slot
  // for its result next cycle. During reset count is 0, so this is 1.
  assign mul_ready_o = (32'(w_count) + 32'(mul_valid_i)) < 32'(DEPTH);

  a_no_overflow : assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(w_push && w_full && !w_pop)
  ) else $error("mul_wb_collector: multiplier result pushed into full buffer");

endmodule
`default_nettype wire

// File: tb/tb_mul_wb_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mul_wb_collector                                          |
// | Description : Directed, table-driven bench for mul_wb_collector (DEPTH=2), |
// |               plus hand-written reset sequences.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mul_wb_collector;

  localparam int C_XLEN = mul_wb_collector_pkg::XLEN;
  localparam int C_TID  = mul_wb_collector_pkg::TRANS_ID_BITS;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              mul_valid;
  logic [C_XLEN-1:0] mul_result;
  logic [C_TID-1:0]  mul_trans_id;
  logic              mul_ready;
  logic              div_valid;
  logic [C_XLEN-1:0] div_result;
  logic [C_TID-1:0]  div_trans_id;
  logic              div_ready;
  logic              wb_valid;
  logic [C_XLEN-1:0] wb_result;
  logic [C_TID-1:0]  wb_trans_id;
  logic              wb_ready;

  int total = 0;
  int bad   = 0;

  mul_wb_collector #(
    .DEPTH         (2),
    .TRANS_ID_BITS (C_TID)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .mul_valid_i    (mul_valid),
    .mul_result_i   (mul_result),
    .mul_trans_id_i (mul_trans_id),
    .mul_ready_o    (mul_ready),
    .div_valid_i    (div_valid),
    .div_result_i   (div_result),
    .div_trans_id_i (div_trans_id),
    .div_ready_o    (div_ready),
    .wb_valid_o     (wb_valid),
    .wb_result_o    (wb_result),
    .wb_trans_id_o  (wb_trans_id),
    .wb_ready_i     (wb_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mv;
    logic [63:0] mres;
    logic [2:0]  mid;
    logic        dv;
    logic [63:0] dres;
    logic [2:0]  did;
    logic        rdy;
    logic        fl;
    logic        ev;
    logic [63:0] eres;
    logic [2:0]  eid;
    logic        emr;
    logic        edr;
    int          ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic mv, input logic [63:0] mres, input logic [2:0] mid,
                     input logic dv, input logic [63:0] dres, input logic [2:0] did,
                     input logic rdy, input logic fl,
                     input logic ev, input logic [63:0] eres, input logic [2:0] eid,
                     input logic emr, input logic edr, input int ecnt);
    vecs.push_back('{mv, mres, mid, dv, dres, did, rdy, fl, ev, eres, eid, emr, edr, ecnt});
  endtask

  task automatic drive(input logic mv, input logic [63:0] mres, input logic [2:0] mid,
                       input logic dv, input logic [63:0] dres, input logic [2:0] did,
                       input logic rdy, input logic fl);
    mul_valid = mv; mul_result = mres; mul_trans_id = mid;
    div_valid = dv; div_result = dres; div_trans_id = did;
    wb_ready = rdy; flush = fl;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [63:0] eres,
                         input logic [2:0] eid, input logic emr, input logic edr, input int ecnt);
    chk({tag, " wb_valid"},    64'(wb_valid),    64'(ev));
    chk({tag, " wb_result"},   64'(wb_result),   eres);
    chk({tag, " wb_trans_id"}, 64'(wb_trans_id), 64'(eid));
    chk({tag, " mul_ready"},   64'(mul_ready),   64'(emr));
    chk({tag, " div_ready"},   64'(div_ready),   64'(edr));
    chk({tag, " count"},       64'(dut.w_count), 64'(ecnt));
  endtask

  initial begin
    //  mv  mres     mid dv  dres     did rdy fl | ev eres     eid mr dr cnt
    // idle and single bypass
    add(0, 64'h0,    0, 0, 64'h0,    0, 1, 0,   0, 64'h0,    0, 1, 0, 0);
    add(1, 64'h1234, 3, 0, 64'h0,    0, 1, 0,   1, 64'h1234, 3, 1, 0, 0);
    add(0, 64'h0,    0, 0, 64'h0,    0, 1, 0,   0, 64'h0,    0, 1, 0, 0);
    // stall buffering: A then B under backpressure, drained in order
    add(1, 64'hA,    1, 0, 64'h0,    0, 0, 0,   1, 64'hA,    1, 1, 0, 0);
    add(1, 64'hB,    2, 0, 64'h0,    0, 0, 0,   1, 64'hA,    1, 0, 0, 1);
    add(0, 64'h0,    0, 0, 64'h0,    0, 0, 0,   1, 64'hA,    1, 0, 0, 2);
    add(0, 64'h0,    0, 0, 64'h0,    0, 1, 0,   1, 64'hA,    1, 0, 0, 2);
    add(0, 64'h0,    0, 0, 64'h0,    0, 1, 0,   1, 64'hB,    2, 1, 0, 1);
    add(0, 64'h0,    0, 0, 64'h0,    0, 1, 0,   0, 64'h0,    0, 1, 0, 0);
    // divider held while two buffered results drain
    add(1, 64'h11,   4, 1, 64'h77,   5, 0, 0,   1, 64'h11,   4, 1, 0, 0);
    add(1, 64'h22,   6, 1, 64'h77,   5, 0, 0,   1, 64'h11,   4, 0, 0, 1);
    add(0, 64'h0,    0, 1, 64'h77,   5, 1, 0,   1, 64'h11,   4, 0, 0, 2);
    add(0, 64'h0,    0, 1, 64'h77,   5, 1, 0,   1, 64'h22,   6, 1, 0, 1);
    add(0, 64'h0,    0, 1, 64'h77,   5, 1, 0,   1, 64'h77,   5, 1, 1, 0);
    add(0, 64'h0,    0, 0, 64'h0,    0, 1, 0,   0, 64'h0,    0, 1, 0, 0);
    // simultaneous push and pop at count=1
    add(1, 64'h33,   1, 0, 64'h0,    0, 0, 0,   1, 64'h33,   1, 1, 0, 0);
    add(1, 64'h44,   2, 0, 64'h0,    0, 1, 0,   1, 64'h33,   1, 0, 0, 1);
    add(0, 64'h0,    0, 0, 64'h0,    0, 1, 0,   1, 64'h44,   2, 1, 0, 1);
    add(0, 64'h0,    0, 0, 64'h0,    0, 1, 0,   0, 64'h0,    0, 1, 0, 0);
    // flush with a full buffer and an arriving pulse
    add(1, 64'h55,   3, 0, 64'h0,    0, 0, 0,   1, 64'h55,   3, 1, 0, 0);
    add(1, 64'h66,   4, 0, 64'h0,    0, 0, 0,   1, 64'h55,   3, 0, 0, 1);
    add(1, 64'h99,   7, 1, 64'h77,   5, 1, 1,   0, 64'h0,    0, 0, 0, 2);
    add(0, 64'h0,    0, 0, 64'h0,    0, 1, 0,   0, 64'h0,    0, 1, 0, 0);
    // divider waits for sink, then handshakes
    add(0, 64'h0,    0, 1, 64'h88,   2, 0, 0,   1, 64'h88,   2, 1, 0, 0);
    add(0, 64'h0,    0, 1, 64'h88,   2, 1, 0,   1, 64'h88,   2, 1, 1, 0);
    add(0, 64'h0,    0, 0, 64'h0,    0, 1, 0,   0, 64'h0,    0, 1, 0, 0);
    // multiplier bypass beats a pending divider
    add(1, 64'h5,    1, 1, 64'h9,    2, 1, 0,   1, 64'h5,    1, 1, 0, 0);
    add(0, 64'h0,    0, 1, 64'h9,    2, 1, 0,   1, 64'h9,    2, 1, 1, 0);
    add(0, 64'h0,    0, 0, 64'h0,    0, 1, 0,   0, 64'h0,    0, 1, 0, 0);

    // reset state, with live inputs that must be masked
    rst = 1'b1;
    drive(1, 64'hDEAD, 1, 1, 64'hBEEF, 2, 1, 0);
    #2;
    chk_out("reset", 0, 64'h0, 0, 1, 0, 0);

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].mv, vecs[i].mres, vecs[i].mid, vecs[i].dv, vecs[i].dres,
            vecs[i].did, vecs[i].rdy, vecs[i].fl);
      #4;
      chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eres, vecs[i].eid,
              vecs[i].emr, vecs[i].edr, vecs[i].ecnt);
    end

    // async reset in the middle of a cycle with two entries buffered
    @(negedge clk);
    drive(1, 64'hC1, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 64'hC2, 2, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 64'hD0, 3, 0, 0);
    #2;
    chk("pre-reset count", 64'(dut.w_count), 64'd2);
    rst = 1'b1;
    #1;
    chk_out("async reset", 0, 64'h0, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #4;
    chk_out("post-reset idle", 0, 64'h0, 0, 1, 0, 0);
    @(negedge clk);
    drive(1, 64'hCAFE, 6, 0, 0, 0, 1, 0);
    #4;
    chk_out("post-reset bypass", 1, 64'hCAFE, 6, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #4;
    chk_out("post-reset drained", 0, 64'h0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
